// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer that feeds COMPUTER. Holds DEPTH slots, each with an
//   instruction and an (x, y) operand pair. When started, it steps a PC
//   through the first len slots. For each slot it spends one FETCH cycle,
//   then issues the slot over valid/ready.
//
// Handshake: an issue is transferred on a rising clk edge where valid && ready.
//   While valid is high, instr_out/addr_out/x_out/y_out stay stable until that
//   edge. ready is ignored while valid is low.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   load_en/addr/...  slot write port (accepted in IDLE only)
//   prog_len          number of slots to run (0..DEPTH, clamped), sampled on start
//   start, abort      run control
//   ready             downstream accept
//   instr_out, addr_out, x_out, y_out, valid   issue to COMPUTER
//   busy, done, load_err                       status
//   state_dbg         current FSM state, for observation
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DW    = 32,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_instr,
    input  logic [DW-1:0] load_x,
    input  logic [DW-1:0] load_y,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic          load_err,
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [AW:0]   len;
    logic [DW-1:0] mem_instr [DEPTH];
    logic [DW-1:0] mem_x     [DEPTH];
    logic [DW-1:0] mem_y     [DEPTH];

    // The status outputs are decoded from the state, so an asynchronous reset
    // drops valid without waiting for a clock edge.
    assign valid     = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            len       <= '0;
            instr_out <= '0;
            addr_out  <= '0;
            x_out     <= '0;
            y_out     <= '0;
            load_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_x[i]     <= '0;
                mem_y[i]     <= '0;
            end
        end else begin
            // A write attempted while a run is in progress is dropped and flagged.
            load_err <= load_en && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        mem_instr[load_addr] <= load_instr;
                        mem_x[load_addr]     <= load_x;
                        mem_y[load_addr]     <= load_y;
                    end
                    // A write in the same cycle as start lands before FETCH
                    // reads the memory, so the run sees the new slot contents.
                    if (start && (prog_len != '0)) begin
                        len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (abort) begin
                        pc    <= '0;
                        state <= S_IDLE;
                    end else begin
                        instr_out <= mem_instr[pc];
                        x_out     <= mem_x[pc];
                        y_out     <= mem_y[pc];
                        addr_out  <= pc;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // abort takes priority over an accept in the same cycle.
                    if (abort) begin
                        pc    <= '0;
                        state <= S_IDLE;
                    end else if (ready) begin
                        if ({1'b0, pc} == (len - ONE_L)) begin
                            state <= S_DONE;
                        end else begin
                            pc    <= pc + PC_ONE;
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    // S_DONE: one-cycle done pulse. The data registers keep
                    // the last issue.
                    pc    <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed bench for instr_sequencer. Each scenario task drives stimulus and
//   checks outputs against hand-computed values. Outputs are sampled 1 ns
//   after the rising edge, and inputs are changed at that same point.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_instr;
    logic [DW-1:0] load_x;
    logic [DW-1:0] load_y;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic          ready;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] x_out;
    logic [DW-1:0] y_out;
    logic          valid;
    logic          busy;
    logic          done;
    logic          load_err;
    logic [1:0]    state_dbg;

    int n_cmp;
    int n_err;

    // Bench-side copy of what has been written into each slot.
    logic [DW-1:0] e_instr [DEPTH];
    logic [DW-1:0] e_x     [DEPTH];
    logic [DW-1:0] e_y     [DEPTH];

    logic [AW-1:0] exp_q [$];

    instr_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_instr (load_instr),
        .load_x     (load_x),
        .load_y     (load_y),
        .prog_len   (prog_len),
        .start      (start),
        .abort      (abort),
        .ready      (ready),
        .instr_out  (instr_out),
        .addr_out   (addr_out),
        .x_out      (x_out),
        .y_out      (y_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_slot(input logic [AW-1:0] a, input logic [DW-1:0] i,
                             input logic [DW-1:0] x, input logic [DW-1:0] y);
        load_en    = 1'b1;
        load_addr  = a;
        load_instr = i;
        load_x     = x;
        load_y     = y;
        tick();
        load_en    = 1'b0;
        e_instr[a] = i;
        e_x[a]     = x;
        e_y[a]     = y;
    endtask

    task automatic kick(input logic [AW:0] n);
        prog_len = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({valid, busy, done, load_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_status got=%b exp=0000", {valid, busy, done, load_err});
        end
        n_cmp++;
        if (instr_out !== '0 || addr_out !== '0 || x_out !== '0 || y_out !== '0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%0d/%h/%h exp=0", instr_out, addr_out, x_out, y_out);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] ti [3];
        logic [DW-1:0] tx [3];
        logic [DW-1:0] ty [3];
        ti[0] = 32'h543;  ti[1] = 32'h1543; ti[2] = 32'h2543;
        tx[0] = 32'd3;    tx[1] = 32'd5;    tx[2] = 32'd5;
        ty[0] = 32'd4;    ty[1] = 32'd16;   ty[2] = 32'd16;
        for (int s = 0; s < 3; s++) load_slot(AW'(s), ti[s], tx[s], ty[s]);
        ready = 1'b1;
        kick(4'd3);
        for (int s = 0; s < 3; s++) begin
            // Now in FETCH.
            n_cmp++;
            if (valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_fetch%0d valid/busy got=%b%b exp=01", s, valid, busy);
            end
            tick();
            n_cmp++;
            if (valid !== 1'b1 || addr_out !== AW'(s) || instr_out !== ti[s] ||
                x_out !== tx[s] || y_out !== ty[s]) begin
                n_err++;
                $display("FAIL basic_issue%0d got v=%b a=%0d i=%h x=%0d y=%0d exp a=%0d i=%h x=%0d y=%0d",
                         s, valid, addr_out, instr_out, x_out, y_out, s, ti[s], tx[s], ty[s]);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done got done=%b valid=%b exp done=1 valid=0", done, valid);
        end
        n_cmp++;
        if (instr_out !== 32'h2543) begin
            n_err++;
            $display("FAIL basic_hold got=%h exp=2543", instr_out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        kick(4'd3);
        tick();                       // ISSUE slot 0
        ready = 1'b1;
        tick();                       // FETCH slot 1
        ready = 1'b0;
        tick();                       // ISSUE slot 1
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (valid !== 1'b1 || addr_out !== 3'd1 || instr_out !== 32'h1543 ||
                x_out !== 32'd5 || y_out !== 32'd16) begin
                n_err++;
                $display("FAIL stall_hold%0d got v=%b a=%0d i=%h x=%0d y=%0d exp v=1 a=1 i=1543 x=5 y=16",
                         c, valid, addr_out, instr_out, x_out, y_out);
            end
        end
        ready = 1'b1;
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_resume_fetch valid got=%b exp=0", valid);
        end
        tick();
        n_cmp++;
        if (valid !== 1'b1 || addr_out !== 3'd2 || instr_out !== 32'h2543) begin
            n_err++;
            $display("FAIL stall_slot2 got v=%b a=%0d i=%h exp v=1 a=2 i=2543", valid, addr_out, instr_out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_done got=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_zero_len();
        ready = 1'b1;
        kick(4'd0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len%0d got busy=%b valid=%b exp 0 0", c, busy, valid);
            end
            tick();
        end
    endtask

    task automatic test_full_len();
        bit seen_done;
        logic [AW-1:0] ea;
        int issues;
        for (int s = 3; s < DEPTH; s++)
            load_slot(AW'(s), 32'h100 + DW'(s), DW'(s * 2), DW'(s * 3));
        for (int s = 0; s < DEPTH; s++) exp_q.push_back(AW'(s));
        ready     = 1'b1;
        seen_done = 1'b0;
        issues    = 0;
        kick(4'd9);
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (valid === 1'b1) begin
                issues++;
                ea = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if (addr_out !== ea || instr_out !== e_instr[ea] || x_out !== e_x[ea] ||
                    y_out !== e_y[ea]) begin
                    n_err++;
                    $display("FAIL full_issue got a=%0d i=%h x=%0d y=%0d exp a=%0d i=%h x=%0d y=%0d",
                             addr_out, instr_out, x_out, y_out, ea, e_instr[ea], e_x[ea], e_y[ea]);
                end
            end
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (!seen_done || issues != DEPTH) begin
            n_err++;
            $display("FAIL full_count got issues=%0d done=%b exp issues=8 done=1", issues, seen_done);
        end
        exp_q.delete();
    endtask

    task automatic test_abort();
        bit bad;
        ready = 1'b1;
        kick(4'd3);
        tick();                       // ISSUE 0
        tick();                       // FETCH 1
        tick();                       // ISSUE 1
        n_cmp++;
        if (valid !== 1'b1 || addr_out !== 3'd1) begin
            n_err++;
            $display("FAIL abort_pre got v=%b a=%0d exp v=1 a=1", valid, addr_out);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle got busy=%b valid=%b done=%b exp 000", busy, valid, done);
        end
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL abort_quiet got activity after abort exp none");
        end
        kick(4'd3);
        tick();
        n_cmp++;
        if (valid !== 1'b1 || addr_out !== 3'd0 || instr_out !== 32'h543) begin
            n_err++;
            $display("FAIL abort_restart got v=%b a=%0d i=%h exp v=1 a=0 i=543", valid, addr_out, instr_out);
        end
        for (int c = 0; c < 20 && done !== 1'b1; c++) tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL abort_rerun_done got=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_load_err();
        ready = 1'b0;
        kick(4'd3);
        tick();                       // ISSUE 0, stalled
        load_en    = 1'b1;
        load_addr  = 3'd0;
        load_instr = 32'hdead;
        load_x     = 32'hbeef;
        load_y     = 32'hcafe;
        tick();
        load_en = 1'b0;
        n_cmp++;
        if (load_err !== 1'b1) begin
            n_err++;
            $display("FAIL load_err_pulse got=%b exp=1", load_err);
        end
        tick();
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_err++;
            $display("FAIL load_err_clear got=%b exp=0", load_err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b1;
        kick(4'd1);
        tick();
        n_cmp++;
        if (instr_out !== 32'h543 || x_out !== 32'd3 || y_out !== 32'd4) begin
            n_err++;
            $display("FAIL load_err_slot got i=%h x=%0d y=%0d exp i=543 x=3 y=4", instr_out, x_out, y_out);
        end
        tick();
        tick();
    endtask

    task automatic test_load_start();
        load_en    = 1'b1;
        load_addr  = 3'd0;
        load_instr = 32'h777;
        load_x     = 32'd7;
        load_y     = 32'd9;
        ready      = 1'b1;
        kick(4'd1);
        load_en = 1'b0;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || instr_out !== 32'h777 || x_out !== 32'd7 || y_out !== 32'd9) begin
            n_err++;
            $display("FAIL load_start got v=%b i=%h x=%0d y=%0d exp v=1 i=777 x=7 y=9",
                     valid, instr_out, x_out, y_out);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        kick(4'd3);
        tick();                       // ISSUE 0
        n_cmp++;
        if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre valid got=%b exp=1", valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async got valid=%b busy=%b exp 0 0", valid, busy);
        end
        tick();
        reset = 1'b1;
        ready = 1'b1;
        kick(4'd1);
        tick();
        n_cmp++;
        if (valid !== 1'b1 || instr_out !== '0 || x_out !== '0 || y_out !== '0) begin
            n_err++;
            $display("FAIL rst_mid_mem got v=%b i=%h x=%h y=%h exp v=1 i=0 x=0 y=0",
                     valid, instr_out, x_out, y_out);
        end
        tick();
        tick();
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_instr = '0;
        load_x     = '0;
        load_y     = '0;
        prog_len   = '0;
        start      = 1'b0;
        abort      = 1'b0;
        ready      = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            e_instr[s] = '0;
            e_x[s]     = '0;
            e_y[s]     = '0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_full_len();
        test_abort();
        test_load_err();
        test_load_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
